// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - D-cache line refill/writeback to 32-bit INCR burst bridge
module cache_axi_bridge #(
    parameter int LINE_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rd_req,
    input  logic [31:0]               rd_addr,
    output logic                      rd_rdy,
    output logic                      ret_valid,
    output logic                      ret_last,
    output logic [31:0]               ret_data,
    input  logic                      wr_req,
    input  logic [31:0]               wr_addr,
    input  logic [32*LINE_WORDS-1:0]  wr_data,
    output logic                      wr_rdy,
    output logic [31:0]               araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [31:0]               rdata,
    input  logic                      rvalid,
    input  logic                      rlast,
    output logic                      rready,
    output logic [31:0]               awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [31:0]               wdata,
    output logic                      wvalid,
    input  logic                      wready,
    output logic                      wlast,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    rd_state_t                r_rd_state;
    wr_state_t                r_wr_state;
    logic [31:0]              r_araddr;
    logic [31:0]              r_awaddr;
    logic [32*LINE_WORDS-1:0] r_line;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;

    logic                     w_wr_rdy;
    logic                     w_wr_accept;
    logic                     w_hazard;
    logic                     w_rd_rdy;
    logic                     w_unused;

    // Offset bits within a line are don't-care on both request ports
    assign w_unused = &{1'b0, rd_addr[5:0], wr_addr[5:0]};

    // A refill must not overtake a writeback of the same line, whether in flight or accepted now
    assign w_wr_rdy    = (r_wr_state == W_IDLE);
    assign w_wr_accept = wr_req && w_wr_rdy;
    assign w_hazard    = ((r_wr_state != W_IDLE) && (rd_addr[31:6] == r_awaddr[31:6])) ||
                         (w_wr_accept && (rd_addr[31:6] == wr_addr[31:6]));
    assign w_rd_rdy    = (r_rd_state == R_IDLE) && !w_hazard;

    assign rd_rdy    = w_rd_rdy;
    assign wr_rdy    = w_wr_rdy;
    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;

    // Refill beats pass straight through to the cache while a read burst is in its data phase
    assign ret_valid = r_rready && rvalid;
    assign ret_last  = r_rready && rlast;
    assign ret_data  = r_rready ? rdata : 32'd0;

    // Write beat is selected from the line buffer by the beat counter
    assign wdata = r_wvalid ? r_line[{r_beat, 5'b0} +: 32] : 32'd0;
    assign wlast = r_wvalid && (r_beat == LAST_BEAT);

    // Read channel FSM: address phase, then data until rlast
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= R_IDLE;
            r_araddr   <= 32'd0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (rd_req && w_rd_rdy) begin
                        r_araddr   <= {rd_addr[31:6], 6'b0};
                        r_arvalid  <= 1'b1;
                        r_rd_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        r_rready   <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_arvalid  <= 1'b0;
                    r_rready   <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // Write channel FSM: address, counted data beats, then response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_awaddr   <= 32'd0;
            r_line     <= '0;
            r_beat     <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_accept) begin
                        r_awaddr   <= {wr_addr[31:6], 6'b0};
                        r_line     <= wr_data;
                        r_beat     <= '0;
                        r_awvalid  <= 1'b1;
                        r_wr_state <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        r_awvalid  <= 1'b0;
                        r_wvalid   <= 1'b1;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_wvalid   <= 1'b0;
                            r_bready   <= 1'b1;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        r_bready   <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_awvalid  <= 1'b0;
                    r_wvalid   <= 1'b0;
                    r_bready   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule
